// File: rtl/slice_rate_buffer.sv
// Per-slice elastic buffer: RAM plus a registered output word, valid/ready drain side.
// Optional statistics (peak_level, drop_cnt) are built when SLICE_RATE_BUF_STATS_EN is defined.
module slice_rate_buffer #(
  parameter int DATA_W       = 256,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow
`ifdef SLICE_RATE_BUF_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   peak_level,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int RD = DEPTH - 1;

  logic [DATA_W:0]  mem [RD];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    ram_cnt;
  logic [DATA_W:0]  head;

  logic             clr;
  logic             pop;
  logic             full;
  logic             push;
  logic             drop;
  logic             ram_empty;
  logic             load;
  logic             ram_rd;
  logic             bypass;
  logic             ram_wr;
  logic [LW-1:0]    level_nxt;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(RD - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    clr       = rst | flush;
    pop       = out_valid & out_ready;
    full      = (level == LW'(DEPTH));
    push      = in_valid & ~clr & (~full | pop);
    drop      = in_valid & ~clr & full & ~pop;
    ram_empty = (ram_cnt == '0);
    // Output register refills whenever it is empty or being consumed.
    load      = ~out_valid | pop;
    ram_rd    = load & ~ram_empty;
    bypass    = load & ram_empty & push;
    ram_wr    = push & ~bypass;
    head      = mem[rd_ptr];
    level_nxt = level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      level       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (ram_wr) wr_ptr <= inc(wr_ptr);
      if (ram_rd) rd_ptr <= inc(rd_ptr);
      ram_cnt <= ram_cnt + PW'(ram_wr) - PW'(ram_rd);
      if (load) begin
        out_valid <= ram_rd | bypass;
        out_sof   <= ram_rd ? head[DATA_W]
                            : (bypass & in_sof);
      end
      level       <= level_nxt;
      almost_full <= (level_nxt >= LW'(AFULL_THRESH));
      if (drop) overflow <= 1'b1;
    end
  end

  // Payload path carries no reset.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= {in_sof, in_data};
    if (ram_rd) out_data <= head[DATA_W-1:0];
    else if (bypass) out_data <= in_data;
  end

`ifdef SLICE_RATE_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      peak_level <= '0;
      drop_cnt   <= '0;
    end else begin
      if (level_nxt > peak_level) peak_level <= level_nxt;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slice_rate_buffer.sv
// Scoreboard bench for slice_rate_buffer: queue-based reference model,
// directed corner cases followed by randomized push/pop/flush traffic.
module tb_slice_rate_buffer;

  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int LW    = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overflow;
`ifdef SLICE_RATE_BUF_STATS_EN
  logic [LW-1:0] peak_level;
  logic [15:0]   drop_cnt;
`endif

  slice_rate_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_sof(in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sof(out_sof),
    .level(level),
    .almost_full(almost_full),
    .overflow(overflow)
`ifdef SLICE_RATE_BUF_STATS_EN
    ,
    .peak_level(peak_level),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0] sb_q[$];
  int          m_level = 0;
  bit          m_ovf   = 0;
  int          m_peak  = 0;
  int          m_drop  = 0;
  bit          started = 0;

  task automatic chk(input string nm,
                     input logic [DW:0] act,
                     input logic [DW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: word list plus occupancy count.
  always @(posedge clk) begin : model
    bit pop;
    bit acc;
    started = 1;
    if (rst || flush) begin
      sb_q.delete();
      m_level = 0;
      m_ovf   = 0;
      m_peak  = 0;
      m_drop  = 0;
    end else begin
      pop = (m_level > 0) && out_ready;
      acc = 0;
      if (in_valid) begin
        if (m_level < DEPTH || pop) begin
          sb_q.push_back({in_sof, in_data});
          acc = 1;
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      m_level = m_level + int'(acc) - int'(pop);
      if (m_level > m_peak) m_peak = m_level;
    end
  end

  bit          prev_hold = 0;
  logic [DW:0] prev_word;

  always @(negedge clk) begin : monitor
    if (started) begin
      chk("level", level, m_level);
      chk("out_valid", out_valid, m_level != 0);
      chk("almost_full", almost_full, m_level >= DEPTH - 4);
      chk("overflow", overflow, m_ovf);
`ifdef SLICE_RATE_BUF_STATS_EN
      chk("peak_level", peak_level, m_peak);
      chk("drop_cnt", drop_cnt, m_drop);
`endif
      if (prev_hold && out_valid)
        chk("hold_stable", {out_sof, out_data}, prev_word);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_order: got %h expected none",
                   {out_sof, out_data});
        end else begin
          chk("pop_word", {out_sof, out_data}, sb_q.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {out_sof, out_data};
    end
  end

  task automatic drive(input bit v, input bit s, input bit r,
                       input bit f, input logic [DW-1:0] d);
    in_valid  = v;
    in_sof    = s;
    out_ready = r;
    flush     = f;
    in_data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      drive(1, 1'($urandom), 0, 0, rnd());
  endtask

  logic [DW-1:0] d0;

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_sof = 0;
    out_ready = 0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sof", out_sof, 0);
    rst = 0;

    // Bypass latency into an empty buffer
    d0 = rnd();
    drive(1, 1, 1, 0, d0);
    chk("t1_valid", out_valid, 1);
    chk("t1_word", {out_sof, out_data}, {1'b1, d0});
    chk("t1_level", level, 1);
    drive(0, 0, 1, 0, '0);
    chk("t1_level0", level, 0);

    // Fill to capacity, then one dropped push
    fill(DEPTH);
    chk("t2_level", level, DEPTH);
    chk("t2_afull", almost_full, 1);
    chk("t2_ovf0", overflow, 0);
    drive(1, 0, 0, 0, rnd());
    chk("t2_level_drop", level, DEPTH);
    chk("t2_ovf1", overflow, 1);

    // Push and pop together on a full buffer, then drain
    drive(0, 0, 0, 1, '0);
    fill(DEPTH);
    drive(1, 1, 1, 0, rnd());
    chk("t3_level", level, DEPTH);
    chk("t3_ovf", overflow, 0);
    repeat (DEPTH + 6) drive(0, 0, 1, 0, '0);
    chk("t3_empty", level, 0);

    // Flush beats push with overflow set
    fill(DEPTH);
    drive(1, 0, 0, 0, rnd());
    repeat (DEPTH - 20) drive(0, 0, 1, 0, '0);
    chk("t5_level20", level, 20);
    chk("t5_ovf", overflow, 1);
    drive(1, 1, 0, 1, rnd());
    chk("t5_flush_level", level, 0);
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_ovf", overflow, 0);
    d0 = rnd();
    drive(1, 0, 0, 0, d0);
    chk("t5_push_valid", out_valid, 1);
    chk("t5_push_word", {out_sof, out_data}, {1'b0, d0});
    drive(0, 0, 1, 0, '0);

`ifdef SLICE_RATE_BUF_STATS_EN
    drive(0, 0, 0, 1, '0);
    fill(DEPTH);
    repeat (3) drive(1, 0, 0, 0, rnd());
    chk("t6_drop_cnt", drop_cnt, 3);
    chk("t6_peak", peak_level, DEPTH);
    drive(0, 0, 0, 1, '0);
    chk("t6_drop_clr", drop_cnt, 0);
    chk("t6_peak_clr", peak_level, 0);
`endif

    // Random traffic: ~50% push, ~30% ready, rare flush, stray sof
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(1) == 1, 1'($urandom),
            $urandom_range(9) < 3, $urandom_range(499) == 0,
            rnd());

    drive(0, 0, 0, 0, '0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
